// File: rtl/fir_decim.sv
// Decimating FIR filter: circular sample history, one MAC per cycle,
// rounded/saturated output with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active high), clear (flush history and phase),
//   in_valid/in_ready/data_in  : sample input handshake
//   coeff                      : packed signed taps, tap k at [CW*k +: CW]
//   out_valid/out_ready/data_out/sat : filtered output handshake
module fir_decim #(
  parameter int DATA_WIDTH  = 12,
  parameter int COEFF_WIDTH = 8,
  parameter int NUM_TAPS    = 4,
  parameter int DECIM       = 1,
  parameter int OUT_WIDTH   = 12,
  parameter int OUT_SHIFT   = COEFF_WIDTH - 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        data_in,
  input  logic [COEFF_WIDTH*NUM_TAPS-1:0]     coeff,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_WIDTH-1:0]         data_out,
  output logic                                sat
);

  localparam int KW = $clog2(NUM_TAPS);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW = PW + KW;
  localparam int RW = (AW + 1 > OUT_WIDTH) ? AW + 1 : OUT_WIDTH + 1;
  localparam int TW = RW - OUT_WIDTH + 1;
  localparam logic [KW-1:0] KMAX = KW'(NUM_TAPS - 1);
  localparam logic [DW-1:0] DMAX = DW'(DECIM - 1);
  localparam int RSH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] RND =
    (OUT_SHIFT > 0) ? (RW'(1) << RSH) : '0;

  // FIN is the single cycle that rounds/clamps the finished sum.
  typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_t;

  state_t state, state_n;

  logic signed [DATA_WIDTH-1:0]  hist [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] cq   [NUM_TAPS];
  logic [KW-1:0]                 wptr, rptr, k;
  logic [DW-1:0]                 dcnt;
  logic signed [AW-1:0]          acc;
  logic signed [PW-1:0]          prod;
  logic signed [RW-1:0]          rsum, r;
  logic [TW-1:0]                 top;
  logic                          ovf;
  logic signed [OUT_WIDTH-1:0]   clip;
  logic                          accept, last_ph, last_tap;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last_ph  = (dcnt == DMAX);
  assign last_tap = (k == KMAX);

  assign prod = cq[k] * hist[rptr];
  assign rsum = acc + RND;
  assign r    = rsum >>> OUT_SHIFT;

  // In range iff all bits from the output sign bit upward agree.
  assign top  = r[RW-1:OUT_WIDTH-1];
  assign ovf  = !((&top) || (~|top));

  always_comb begin
    clip = r[OUT_WIDTH-1:0];
    if (ovf) begin
      clip = r[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept && last_ph) state_n = MAC;
      MAC:  if (last_tap) state_n = FIN;
      FIN:  state_n = OUT;
      OUT:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      rptr      <= '0;
      k         <= '0;
      dcnt      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat       <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist[i] <= '0;
        cq[i]   <= '0;
      end
    end else begin
      state <= state_n;
      if (clear) begin
        wptr      <= '0;
        dcnt      <= '0;
        out_valid <= 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) hist[i] <= '0;
      end else begin
        if (accept) begin
          hist[wptr] <= data_in;
          wptr <= (wptr == KMAX) ? '0 : wptr + KW'(1);
          dcnt <= last_ph ? '0 : dcnt + DW'(1);
          if (last_ph) begin
            acc  <= '0;
            k    <= '0;
            // Newest sample sits where the write pointer was.
            rptr <= wptr;
            for (int i = 0; i < NUM_TAPS; i++)
              cq[i] <= coeff[COEFF_WIDTH*i +: COEFF_WIDTH];
          end
        end
        if (state == MAC) begin
          acc  <= acc + prod;
          k    <= k + KW'(1);
          rptr <= (rptr == '0) ? KMAX : rptr - KW'(1);
        end
        if (state == FIN) begin
          data_out  <= clip;
          sat       <= ovf;
          out_valid <= 1'b1;
        end
        if (state == OUT && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_decim.md
FIR_DECIM -- requirements
Module: fir_decim

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: signed input sample width.
REQ-002 SHALL have parameter COEFF_WIDTH, default 8: signed coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 4 (legal range 2..64): filter length.
REQ-004 SHALL have parameter DECIM, default 1 (legal range 1..256): decimation factor.
REQ-005 SHALL have parameter OUT_WIDTH, default 12: signed output width.
REQ-006 SHALL have parameter OUT_SHIFT, default COEFF_WIDTH-1: arithmetic right shift applied to the accumulator before output.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port clear, input, 1 bit: synchronous flush of history and decimation phase.
REQ-010 SHALL have port in_valid, input, 1 bit: data_in is valid.
REQ-011 SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-012 SHALL have port data_in, input, DATA_WIDTH bits: signed sample.
REQ-013 SHALL have port coeff, input, COEFF_WIDTH*NUM_TAPS bits: coeff[COEFF_WIDTH*k +: COEFF_WIDTH] is signed tap k, applied to x[n-k].
REQ-014 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts data_out.
REQ-016 SHALL have port data_out, output, OUT_WIDTH bits: signed filtered, decimated sample.
REQ-017 SHALL have port sat, output, 1 bit: the current data_out was saturated; qualified by out_valid.

Function
REQ-018 SHALL accept a sample on any rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in state IDLE.
REQ-019 SHALL write each accepted sample into an internal NUM_TAPS-deep history (circular buffer, pointer wraps NUM_TAPS-1 -> 0), becoming x[n].
REQ-020 SHALL keep a decimation counter 0..DECIM-1, incremented per accepted sample; the accept at count DECIM-1 SHALL wrap it to 0 and move IDLE -> MAC; other accepts SHALL remain in IDLE.
REQ-021 SHALL capture coeff on the IDLE -> MAC transition; coeff changes during MAC/OUT SHALL NOT affect the running computation.
REQ-022 SHALL spend exactly NUM_TAPS cycles in MAC, one signed multiply-accumulate per cycle, k = 0..NUM_TAPS-1: acc += c[k]*x[n-k]; acc SHALL be cleared at MAC entry.
REQ-023 SHALL size acc as DATA_WIDTH+COEFF_WIDTH+clog2(NUM_TAPS) bits, so that no internal overflow can occur.
REQ-024 SHALL, on MAC exit, form r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (no rounding term when OUT_SHIFT=0).
REQ-025 SHALL clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], register the result into data_out, set sat=1 if clamping occurred (else 0), assert out_valid and enter OUT.
REQ-026 SHALL raise out_valid exactly NUM_TAPS+1 rising edges after the accepting edge.
REQ-027 SHALL hold data_out, sat and out_valid stable in OUT while out_ready=0; the edge with out_valid=1 and out_ready=1 SHALL clear out_valid and return to IDLE.
REQ-028 SHALL keep in_ready=0 in MAC and OUT; upstream is back-pressured and no sample is lost or duplicated.
REQ-029 SHALL treat clear=1 (rst=0) as follows: zero the history and pointer, zero the decimation counter, drop out_valid, and go to IDLE, from any state; clear SHALL take priority over a simultaneous accept.
REQ-030 SHALL leave data_out and sat unchanged on clear; they are only meaningful while out_valid=1.

Reset
REQ-031 SHALL, while rst=1 at a rising edge, set state=IDLE, history=0, pointer=0, decimation counter=0, acc=0, out_valid=0, data_out=0 and sat=0; in_ready SHALL read 1 on the first cycle after rst is released.
REQ-032 SHALL give rst priority over clear and all handshakes; rst mid-MAC or mid-OUT SHALL abort the result, with no out_valid afterwards.

Verification
REQ-033 Impulse: NUM_TAPS=4, DECIM=1, OUT_SHIFT=0, coeff taps {10,20,30,40}, out_ready=1; drive 1,0,0,0,0 -> data_out 10,20,30,40,0, sat=0, each out_valid exactly 5 edges after its accept.
REQ-034 Decimation: DECIM=2, NUM_TAPS=4, OUT_SHIFT=0, all taps 1; feed 1,2,3,4,5,6 -> outputs 3,10,18 only (after inputs 2, 4, 6).
REQ-035 Saturation/rounding: OUT_WIDTH=12, OUT_SHIFT=0, all taps 127; constant 2047 -> data_out 2047, sat=1; constant -2048 -> data_out -2048, sat=1. OUT_SHIFT=1, taps {1,0,0,0}, input 3 -> data_out 2, sat=0.
REQ-036 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> data_out stable, in_ready=0 throughout, in_valid samples not accepted; release -> single transfer, then IDLE.
REQ-037 Reset/clear mid-operation: assert rst in MAC cycle 2 -> no out_valid, in_ready=1 on the next cycle, next impulse reproduces REQ-033; clear with in_valid=1 -> sample dropped, history zeroed, decimation phase restarts at 0.
